seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receive-side counterpart of the multiplexed 7-segment display path. It samples the 12-bit scanned segment bus (anode select plus cathodes) and recovers the four digits and decimal points. Once a value has been stable for enough frames, it converts the digits back to a 14-bit binary value. It is used for on-chip loopback self-test of the display driver and for reading back another board's display.

## Interface
- SETTLE_CYCLES, default 16: cycles to wait after an anode change before sampling cathodes. Legal range is 2 to 65535.
- STABLE_FRAMES, default 2: number of consecutive identical complete frames required before publishing. Minimum 1.
- CLK  in  1: single system clock. All logic is rising-edge.
- RESET_N  in  1: asynchronous, active-low reset.
- SEG_IN  in  12: scanned bus, all bits active-low.
  - [11:8] is the anode select: 1110 = digit 0 (rightmost), 1101 = digit 1, 1011 = digit 2, 0111 = digit 3.
  - [7] is DP. [6:0] is {g,f,e,d,c,b,a}.
- BIN_OUT  out  14: last published value, 0 to 9999.
- DOT_OUT  out  4: DP state per digit of the last published frame, 1 = lit.
- BLANK_OUT  out  4: per-digit flag, 1 = digit was fully dark.
- VALID  out  1: one-cycle pulse when BIN_OUT, DOT_OUT and BLANK_OUT update.
- ERROR  out  1: one-cycle pulse when a frame is discarded.

## Operation
- **Input register:** SEG_IN is registered once; all logic uses the registered copy.
- **Anode decode:**
  - A one-hot-low anode pattern gives index 0 to 3.
  - 1111 or any multi-hot pattern means "no digit": the settle counter is held at 0 and nothing is captured.
- **Settle counter:**
  - Cleared whenever the registered anode field differs from its previous value.
  - Counts up to SETTLE_CYCLES and saturates there.
  - A capture happens in the single cycle where the count equals SETTLE_CYCLES, so there is exactly one capture per anode dwell.
- **Capture:**
  - Glyph decode of [6:0] is written into digit[idx], DP into dot[idx], and seen[idx] is set.
  - A recapture of an already-seen index overwrites it.
- **Glyph decode** (active-low {g..a} to digit):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - 1111111 gives digit 0 with blank = 1.
  - Any other pattern sets the frame's bad flag.
- **Frame completion:** when seen becomes 1111, the cycle after the fourth capture does all of the following:
  - Clears seen and the bad flag.
  - If bad was set: pulse ERROR, reset the match count to 0, and discard the frame.
  - Otherwise compare {digits, dots, blanks} with the previous good frame. Increment the match count (saturating) if equal; set it to 1 if different. Store the frame as the previous good frame.
  - If match count equals STABLE_FRAMES and the frame differs from the last published frame, go to CONVERT with a snapshot of the frame.
- **State machine:**
  - COLLECT: capture and compare run continuously; this is the reset state.
  - CONVERT: 4 cycles, i = 3 down to 0, computing acc = acc*10 + digit[i]. acc is 14 bits, acc*10 is formed as (acc<<3)+(acc<<1), and there is no overflow since the maximum is 9999.
  - PUBLISH: 1 cycle. Load the outputs from acc and the snapshot, pulse VALID, return to COLLECT.
- Capture and comparison continue during CONVERT and PUBLISH. The minimum frame time of 4×(SETTLE_CYCLES+1) ≥ 12 cycles means no second publish request can arise before PUBLISH ends.
- The same stable value is never re-published. After reset, the first stable frame always publishes, even if it is all zeros.

## Timing
- **Reset values:** BIN_OUT = 0, DOT_OUT = 0, BLANK_OUT = 0, VALID = 0, ERROR = 0. Also cleared: state COLLECT, seen = 0, match count = 0, previous good frame and published frame invalid.
- **Latency:** with the fourth qualifying capture in cycle N:
  - Frame compare in N+1.
  - CONVERT in N+2 to N+5.
  - VALID and the new outputs in N+6.
- **Anode change to capture:** SETTLE_CYCLES+1 cycles after the change is seen on the registered bus.
- ERROR pulses in cycle N+1.
- Outputs hold between VALID pulses.
- **Reset mid-operation:** RESET_N low clears everything asynchronously. A conversion in progress is abandoned, no VALID is produced, and collection restarts from an empty frame after release.

## Structure
- **Package seg7_pkg:**
  - Glyph constants GLYPH_0 to GLYPH_9 and GLYPH_BLANK.
  - Anode codes AN_DIG0 to AN_DIG3 and AN_NONE.
  - State enum {COLLECT, CONVERT, PUBLISH}.
- **Sub-module seg7_glyph_decode:** combinational, 7-bit in, outputs digit[3:0], blank and bad.
- Everything else lives in seg7_scan_decoder.

## Test plan
- Clean scan of 1234, DP on digit 2, 20-cycle dwell, default parameters: VALID exactly once, in the second frame, with BIN_OUT = 1234, DOT_OUT = 0100, BLANK_OUT = 0000. No further VALID while the scan repeats.
- Scan 0042 with digits 3 and 2 dark: BIN_OUT = 42, BLANK_OUT = 1100.
- Digit 1 driven as 1010101 in one frame: ERROR pulses in N+1 and no VALID. After that, two clean frames of 0007 give VALID with BIN_OUT = 7.
- Value changes from 9999 to 0001 mid-run: VALID with 9999, then exactly one VALID with 1 after two frames of 0001.
- Glitch where the anode reverts to its previous value after 5 cycles, with SETTLE_CYCLES = 16: no capture occurs during the glitch dwell.
- RESET_N asserted at CONVERT cycle 2 of a 5678 publish: all outputs are 0, no VALID. After release, two clean frames give VALID with 5678 exactly 6 cycles after the final capture.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the scanned 7-segment display receiver.
package seg7_pkg;

    // Active-low cathode patterns {g,f,e,d,c,b,a} for each decimal digit.
    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // Active-low anode selects; digit 0 is the rightmost position.
    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;
    localparam logic [3:0] AN_NONE = 4'b1111;

    typedef enum logic [1:0] {
        COLLECT,
        CONVERT,
        PUBLISH
    } state_e;

    // One recovered display frame; index i of each field is digit position i.
    typedef struct packed {
        logic [3:0][3:0] digits;
        logic [3:0]      dots;
        logic [3:0]      blanks;
    } frame_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Maps an active-low cathode pattern back to a BCD digit.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] glyph_i,
    output logic [3:0] digit_o,
    output logic       blank_o,
    output logic       bad_o
);

    // Dark glyph reads as digit 0 with blank set; unknown patterns flag bad.
    always_comb begin
        digit_o = 4'd0;
        blank_o = 1'b0;
        bad_o   = 1'b0;
        case (glyph_i)
            GLYPH_0:     digit_o = 4'd0;
            GLYPH_1:     digit_o = 4'd1;
            GLYPH_2:     digit_o = 4'd2;
            GLYPH_3:     digit_o = 4'd3;
            GLYPH_4:     digit_o = 4'd4;
            GLYPH_5:     digit_o = 4'd5;
            GLYPH_6:     digit_o = 4'd6;
            GLYPH_7:     digit_o = 4'd7;
            GLYPH_8:     digit_o = 4'd8;
            GLYPH_9:     digit_o = 4'd9;
            GLYPH_BLANK: blank_o = 1'b1;
            default:     bad_o   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers four digits and decimal points from a scanned 7-segment bus and
// publishes the binary value once the same frame has been seen enough times.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned STABLE_FRAMES = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [11:0] SEG_IN,
    output logic [13:0] BIN_OUT,
    output logic [3:0]  DOT_OUT,
    output logic [3:0]  BLANK_OUT,
    output logic        VALID,
    output logic        ERROR
);

    localparam int unsigned   MW       = $clog2(STABLE_FRAMES + 1);
    localparam logic [15:0]   SETTLE_C = 16'(SETTLE_CYCLES);
    localparam logic [MW-1:0] STABLE_C = MW'(STABLE_FRAMES);

    logic [11:0]   seg_q;
    logic [3:0]    an_prev_q;
    logic [15:0]   cnt_q, cnt_d;
    logic          cap_done_q, cap_done_d;
    logic [3:0][3:0] digits_q;
    logic [3:0]    dots_q, blanks_q, seen_q;
    logic          bad_q;
    frame_t        prev_q, pub_q, snap_q, cur_frame;
    logic          prev_valid_q, pub_valid_q;
    logic [MW-1:0] match_q, match_next;
    state_e        state_q, state_d;
    logic [1:0]    step_q, step_d;
    logic [13:0]   acc_q, acc_d;
    logic [13:0]   bin_q;
    logic [3:0]    dot_q, blank_q;

    logic          an_valid, an_changed, capture;
    logic [1:0]    an_idx;
    logic [3:0]    dec_digit;
    logic          dec_blank, dec_bad;
    logic          frame_done, publish_req;

    seg7_glyph_decode u_glyph (
        .glyph_i (seg_q[6:0]),
        .digit_o (dec_digit),
        .blank_o (dec_blank),
        .bad_o   (dec_bad)
    );

    // Only a single low anode bit selects a digit; idle and multi-hot are ignored.
    always_comb begin
        an_valid = 1'b1;
        an_idx   = 2'd0;
        case (seg_q[11:8])
            AN_DIG0: an_idx = 2'd0;
            AN_DIG1: an_idx = 2'd1;
            AN_DIG2: an_idx = 2'd2;
            AN_DIG3: an_idx = 2'd3;
            default: an_valid = 1'b0;
        endcase
    end

    assign an_changed = (seg_q[11:8] != an_prev_q);

    // Settle counter: one capture per dwell, when the count first sits at its limit.
    always_comb begin
        cnt_d      = cnt_q;
        cap_done_d = cap_done_q;
        capture    = 1'b0;
        if (!an_valid || an_changed) begin
            cnt_d      = 16'd0;
            cap_done_d = 1'b0;
        end else if (cnt_q != SETTLE_C) begin
            cnt_d = cnt_q + 16'd1;
        end else if (!cap_done_q) begin
            capture    = 1'b1;
            cap_done_d = 1'b1;
        end
    end

    // Frame compare terms, evaluated in the cycle after the fourth capture.
    always_comb begin
        cur_frame.digits = digits_q;
        cur_frame.dots   = dots_q;
        cur_frame.blanks = blanks_q;
        frame_done       = (seen_q == 4'hF);
        if (prev_valid_q && (cur_frame == prev_q)) begin
            match_next = (match_q == STABLE_C) ? match_q : match_q + MW'(1);
        end else begin
            match_next = MW'(1);
        end
        publish_req = frame_done && !bad_q && (match_next == STABLE_C) &&
                      !(pub_valid_q && (cur_frame == pub_q)) && (state_q == COLLECT);
    end

    // Conversion FSM: four multiply-accumulate steps from digit 3 down to digit 0.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        case (state_q)
            COLLECT: begin
                if (publish_req) begin
                    state_d = CONVERT;
                    step_d  = 2'd3;
                    acc_d   = 14'd0;
                end
            end
            CONVERT: begin
                acc_d  = (acc_q << 3) + (acc_q << 1) + {10'd0, snap_q.digits[step_q]};
                step_d = step_q - 2'd1;
                if (step_q == 2'd0) state_d = PUBLISH;
            end
            PUBLISH: state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Input register, anode history and settle counter.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            seg_q      <= 12'hFFF;
            an_prev_q  <= AN_NONE;
            cnt_q      <= 16'd0;
            cap_done_q <= 1'b0;
        end else begin
            seg_q      <= SEG_IN;
            an_prev_q  <= seg_q[11:8];
            cnt_q      <= cnt_d;
            cap_done_q <= cap_done_d;
        end
    end

    // Digit capture, frame completion and stability tracking.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            digits_q     <= '0;
            dots_q       <= 4'd0;
            blanks_q     <= 4'd0;
            seen_q       <= 4'd0;
            bad_q        <= 1'b0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            match_q      <= '0;
            pub_q        <= '0;
            pub_valid_q  <= 1'b0;
            snap_q       <= '0;
        end else begin
            if (capture) begin
                digits_q[an_idx] <= dec_digit;
                dots_q[an_idx]   <= ~seg_q[7];
                blanks_q[an_idx] <= dec_blank;
                seen_q[an_idx]   <= 1'b1;
                if (dec_bad) bad_q <= 1'b1;
            end
            if (frame_done) begin
                seen_q <= 4'd0;
                bad_q  <= 1'b0;
                if (bad_q) begin
                    match_q <= '0;
                end else begin
                    match_q      <= match_next;
                    prev_q       <= cur_frame;
                    prev_valid_q <= 1'b1;
                end
            end
            if (publish_req) begin
                pub_q       <= cur_frame;
                pub_valid_q <= 1'b1;
                snap_q      <= cur_frame;
            end
        end
    end

    // FSM state, accumulator and held output registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= COLLECT;
            step_q  <= 2'd0;
            acc_q   <= 14'd0;
            bin_q   <= 14'd0;
            dot_q   <= 4'd0;
            blank_q <= 4'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            if (state_q == PUBLISH) begin
                bin_q   <= acc_q;
                dot_q   <= snap_q.dots;
                blank_q <= snap_q.blanks;
            end
        end
    end

    // New values appear in the PUBLISH cycle itself and are held afterwards.
    assign VALID     = (state_q == PUBLISH);
    assign BIN_OUT   = VALID ? acc_q : bin_q;
    assign DOT_OUT   = VALID ? snap_q.dots : dot_q;
    assign BLANK_OUT = VALID ? snap_q.blanks : blank_q;
    assign ERROR     = frame_done && bad_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed scan sequences checked each cycle against a frame-level model.
module tb_seg7_scan_decoder;

  localparam int S      = 16;
  localparam int STABLE = 2;
  localparam int W      = 54;  // {valid cycle[31:0], bin[13:0], dot[3:0], blank[3:0]}

  localparam logic [3:0] AN0 = 4'b1110;
  localparam logic [3:0] AN1 = 4'b1101;
  localparam logic [3:0] AN2 = 4'b1011;
  localparam logic [3:0] AN3 = 4'b0111;
  localparam logic [6:0] DARK = 7'b1111111;
  localparam logic [6:0] JUNK = 7'b1010101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] seg_in = 12'hFFF;
  logic [13:0] bin_out;
  logic [3:0]  dot_out, blank_out;
  logic        valid, error;

  seg7_scan_decoder #(.SETTLE_CYCLES(S), .STABLE_FRAMES(STABLE)) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .SEG_IN    (seg_in),
    .BIN_OUT   (bin_out),
    .DOT_OUT   (dot_out),
    .BLANK_OUT (blank_out),
    .VALID     (valid),
    .ERROR     (error)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int last_valid_cyc = -1;
  int pub_cap_cyc = -1;
  logic arm_reset = 1'b0;

  logic [W-1:0] exp_q[$];
  int           err_q[$];

  logic [6:0] glyph_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
  endtask

  function automatic logic [6:0] gl(input int d);
    return glyph_tab[d];
  endfunction

  // ---------------- model (frame level) ----------------
  logic [3:0] m_prev_an;
  int         m_run;
  int         m_dig [4];
  logic [3:0] m_dot, m_blank, m_seen;
  logic       m_bad;
  logic [23:0] m_prev_frame, m_pub;
  logic       m_prev_ok, m_pub_ok;
  int         m_match;

  task automatic model_clear();
    m_prev_an = 4'hF; m_run = 0; m_seen = 4'd0; m_bad = 1'b0;
    m_dot = 4'd0; m_blank = 4'd0; m_match = 0;
    m_prev_ok = 1'b0; m_pub_ok = 1'b0;
    for (int k = 0; k < 4; k++) m_dig[k] = 0;
  endtask

  task automatic frame_end();
    logic [23:0] f;
    int val;
    f = {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0]), m_dot, m_blank};
    m_seen = 4'd0;
    if (m_bad) begin
      m_bad = 1'b0;
      m_match = 0;
      err_q.push_back(cyc + 1);
    end else begin
      if (m_prev_ok && f == m_prev_frame) begin
        if (m_match < STABLE) m_match++;
      end else begin
        m_match = 1;
      end
      m_prev_frame = f;
      m_prev_ok = 1'b1;
      if (m_match == STABLE && !(m_pub_ok && f == m_pub)) begin
        m_pub = f;
        m_pub_ok = 1'b1;
        val = m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
        pub_cap_cyc = cyc;
        exp_q.push_back({32'(cyc + 6), 14'(val), m_dot, m_blank});
      end
    end
  endtask

  // A digit is captured once its anode has been held for S+2 consecutive samples.
  task automatic model_step(input logic [11:0] s);
    logic [3:0] an, onehot;
    int idx, d;
    logic blank, bad;
    an = s[11:8];
    if (an == m_prev_an) m_run++;
    else begin m_run = 1; m_prev_an = an; end
    idx = -1;
    for (int k = 0; k < 4; k++) begin
      onehot = 4'b0001 << k;
      if (an == ~onehot) idx = k;
    end
    if (idx >= 0 && m_run == S + 2) begin
      d = 0; blank = 1'b0; bad = 1'b1;
      if (s[6:0] == DARK) begin blank = 1'b1; bad = 1'b0; end
      for (int k = 0; k < 10; k++) if (glyph_tab[k] == s[6:0]) begin d = k; bad = 1'b0; end
      m_dig[idx] = d;
      m_dot[idx] = ~s[7];
      m_blank[idx] = blank;
      m_seen[idx] = 1'b1;
      if (bad) m_bad = 1'b1;
      if (m_seen == 4'hF) frame_end();
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) model_clear();
    else model_step(seg_in);
  end

  // ---------------- scoreboard / per-cycle compare ----------------
  logic [13:0] e_bin = 14'd0;
  logic [3:0]  e_dot = 4'd0, e_blank = 4'd0;

  always @(negedge clk) begin
    logic e_valid, e_err;
    logic [W-1:0] e;
    #1;
    e_valid = 1'b0;
    e_err = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      err_q.delete();
      e_bin = 14'd0; e_dot = 4'd0; e_blank = 4'd0;
    end else begin
      while (exp_q.size() > 0 && int'(exp_q[0][53:22]) < cyc) void'(exp_q.pop_front());
      while (err_q.size() > 0 && err_q[0] < cyc) void'(err_q.pop_front());
      if (exp_q.size() > 0 && int'(exp_q[0][53:22]) == cyc) begin
        e = exp_q.pop_front();
        e_valid = 1'b1;
        e_bin = e[21:8]; e_dot = e[7:4]; e_blank = e[3:0];
      end
      if (err_q.size() > 0 && err_q[0] == cyc) begin
        void'(err_q.pop_front());
        e_err = 1'b1;
      end
    end
    check("valid", 32'(valid), 32'(e_valid));
    check("error", 32'(error), 32'(e_err));
    check("outputs", {10'd0, bin_out, dot_out, blank_out}, {10'd0, e_bin, e_dot, e_blank});
    if (valid) begin valid_cnt++; last_valid_cyc = cyc; end
    if (error) err_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic show(input logic [3:0] an, input logic [6:0] g, input logic dp, input int dwell);
    seg_in = {an, ~dp, g};
    repeat (dwell) @(negedge clk);
  endtask

  task automatic scan_frame(input logic [6:0] g3, input logic [6:0] g2, input logic [6:0] g1,
                            input logic [6:0] g0, input logic [3:0] dots);
    show(AN0, g0, dots[0], 20);
    show(AN1, g1, dots[1], 20);
    show(AN2, g2, dots[2], 20);
    show(AN3, g3, dots[3], 20);
  endtask

  // Pulls reset low during the second CONVERT cycle of the next scheduled publish.
  initial begin : reset_injector
    int tgt;
    wait (arm_reset);
    tgt = -1;
    for (int i = 0; i < 2000 && tgt < 0; i++) begin
      @(negedge clk);
      if (exp_q.size() > 0) tgt = int'(exp_q[0][53:22]) - 3;
    end
    check("reset_target_found", 32'(tgt >= 0), 32'd1);
    if (tgt >= 0) begin
      while (cyc < tgt) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_bin", 32'(bin_out), 32'd0);
      check("midreset_valid", 32'(valid), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int v0, e0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_bin", 32'(bin_out), 32'd0);
    check("reset_dot", 32'(dot_out), 32'd0);
    check("reset_blank", 32'(blank_out), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    rst_n = 1'b1;

    // 1234 with DP on digit 2: one publish only.
    v0 = valid_cnt;
    repeat (4) scan_frame(gl(1), gl(2), gl(3), gl(4), 4'b0100);
    check("t1_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("t1_bin", 32'(bin_out), 32'd1234);
    check("t1_dot", 32'(dot_out), 32'b0100);
    check("t1_blank", 32'(blank_out), 32'd0);

    // 0042 with the two left digits dark.
    v0 = valid_cnt;
    repeat (3) scan_frame(DARK, DARK, gl(4), gl(2), 4'b0000);
    check("t2_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("t2_bin", 32'(bin_out), 32'd42);
    check("t2_blank", 32'(blank_out), 32'b1100);

    // Bad glyph on digit 1, then clean 0007.
    v0 = valid_cnt; e0 = err_cnt;
    scan_frame(gl(0), gl(0), JUNK, gl(7), 4'b0000);
    check("t3_error_count", 32'(err_cnt - e0), 32'd1);
    check("t3_no_valid_on_bad", 32'(valid_cnt - v0), 32'd0);
    repeat (3) scan_frame(gl(0), gl(0), gl(0), gl(7), 4'b0000);
    check("t3_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("t3_bin", 32'(bin_out), 32'd7);
    check("t3_blank", 32'(blank_out), 32'd0);

    // 9999 then 0001.
    v0 = valid_cnt;
    repeat (3) scan_frame(gl(9), gl(9), gl(9), gl(9), 4'b0000);
    check("t4_valid_9999", 32'(valid_cnt - v0), 32'd1);
    check("t4_bin_9999", 32'(bin_out), 32'd9999);
    v0 = valid_cnt;
    repeat (3) scan_frame(gl(0), gl(0), gl(0), gl(1), 4'b0000);
    check("t4_valid_0001", 32'(valid_cnt - v0), 32'd1);
    check("t4_bin_0001", 32'(bin_out), 32'd1);

    // Short anode glitch carrying a junk glyph must not be captured.
    v0 = valid_cnt; e0 = err_cnt;
    repeat (3) begin
      show(AN0, gl(3), 1'b0, 20);
      show(AN1, gl(0), 1'b0, 20);
      show(AN2, JUNK, 1'b0, 5);
      show(AN1, gl(0), 1'b0, 20);
      show(AN2, gl(0), 1'b0, 20);
      show(AN3, gl(0), 1'b0, 20);
    end
    check("t5_no_error", 32'(err_cnt - e0), 32'd0);
    check("t5_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("t5_bin", 32'(bin_out), 32'd3);

    // 5678 with reset during conversion; republished after release.
    v0 = valid_cnt;
    arm_reset = 1'b1;
    repeat (6) scan_frame(gl(5), gl(6), gl(7), gl(8), 4'b0000);
    check("t6_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("t6_bin", 32'(bin_out), 32'd5678);
    check("t6_latency", 32'(last_valid_cyc - pub_cap_cyc), 32'd6);

    seg_in = 12'hFFF;
    repeat (20) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
